// File: rtl/npc_bp.sv
// npc_bp -- next-PC generator for a 5-stage MIPS pipeline whose branch
// compare sits in EX.
//
// Holds the fetch PC and a bimodal table of 2-bit direction counters.
// Jumps (j/jal/jr/jalr) redirect straight from ID. beq/bne are predicted in
// ID, carried into EX in a one-entry record and verified there. A wrong
// prediction steers fetch to the correct path and squashes the single
// wrong-path fetch. Exception entry, eret return and hazard stalls are
// also arbitrated here.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   stall          hazard stall: hold PC, ID instruction not issued to EX
//   jump_op_id     ID op: 0 none, 1 beq, 2 bne, 3 j/jal, 4 jr/jalr, 5-7 none
//   pc_id          PC of the instruction in ID
//   offset_id      branch immediate (word offset)
//   index_id       26-bit jump index
//   gpr_rs_id      forwarded rs value, jr/jalr target
//   cmp_eq_ex      rs==rt for the branch currently in EX
//   exc_req        take an exception this cycle
//   eret_id        eret in ID
//   epc            exception return address, used as-is
//   pc_if          registered fetch PC
//   pc_plus4_if    pc_if + 4 (link value)
//   pc_plus8_if    pc_if + 8 (link value)
//   pred_taken_id  direction prediction for the branch in ID
//   mispredict     EX branch outcome disagrees with its prediction
//   flush_if       clear the IF/ID register at the next edge
//   br_total       resolved branch count (wraps)
//   br_miss        mispredicted branch count (wraps)
module npc_bp #(
  parameter int          BHT_DEPTH  = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [1:0]  CNT_INIT   = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  jump_op_id,
  input  logic [31:0] pc_id,
  input  logic [15:0] offset_id,
  input  logic [25:0] index_id,
  input  logic [31:0] gpr_rs_id,
  input  logic        cmp_eq_ex,
  input  logic        exc_req,
  input  logic        eret_id,
  input  logic [31:0] epc,
  output logic [31:0] pc_if,
  output logic [31:0] pc_plus4_if,
  output logic [31:0] pc_plus8_if,
  output logic        pred_taken_id,
  output logic        mispredict,
  output logic        flush_if,
  output logic [31:0] br_total,
  output logic [31:0] br_miss
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [2:0] OP_BEQ = 3'd1;
  localparam logic [2:0] OP_BNE = 3'd2;
  localparam logic [2:0] OP_J   = 3'd3;
  localparam logic [2:0] OP_JR  = 3'd4;

  // Saturating up/down step of a 2-bit direction counter.
  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    if (up) begin
      res = (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
    end else begin
      res = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
    end
    return res;
  endfunction

  // Architectural state
  logic [31:0]      pc_r;
  logic [1:0]       bht_r [BHT_DEPTH];
  logic             rec_v_r;
  logic             rec_bne_r;
  logic             rec_pred_r;
  logic [IDX_W-1:0] rec_idx_r;
  logic [31:0]      rec_tgt_r;
  logic [31:0]      rec_fall_r;
  logic [31:0]      br_total_r;
  logic [31:0]      br_miss_r;

  // Combinational helpers
  logic             op_br_s;
  logic             op_bne_s;
  logic             op_j_s;
  logic             op_jr_s;
  logic [IDX_W-1:0] id_idx_s;
  logic             pred_s;
  logic [31:0]      tgt_s;
  logic [31:0]      fall_s;
  logic             resolve_s;
  logic             actual_s;
  logic             mispredict_s;
  logic [31:0]      correct_pc_s;
  logic [31:0]      pc_next_s;
  logic             rec_load_s;

  // Decode the ID jump op; codes 5-7 fall through as "no op".
  always_comb begin
    op_br_s  = 1'b0;
    op_bne_s = 1'b0;
    op_j_s   = 1'b0;
    op_jr_s  = 1'b0;
    case (jump_op_id)
      OP_BEQ:  op_br_s = 1'b1;
      OP_BNE: begin
        op_br_s  = 1'b1;
        op_bne_s = 1'b1;
      end
      OP_J:    op_j_s  = 1'b1;
      OP_JR:   op_jr_s = 1'b1;
      default: op_br_s = 1'b0;
    endcase
  end

  assign id_idx_s = pc_id[IDX_W+1:2];
  // Lookup reads the pre-update counter even when EX trains the same entry.
  assign pred_s   = bht_r[id_idx_s][1];
  assign tgt_s    = pc_id + 32'd4 + {{14{offset_id[15]}}, offset_id, 2'b00};
  // Not-taken resumes after the delay slot.
  assign fall_s   = pc_id + 32'd8;

  // An exception kills the EX branch: no resolution, training or redirect.
  assign resolve_s    = rec_v_r & ~exc_req;
  assign actual_s     = rec_bne_r ? ~cmp_eq_ex : cmp_eq_ex;
  assign mispredict_s = resolve_s & (actual_s ^ rec_pred_r);
  assign correct_pc_s = actual_s ? rec_tgt_r : rec_fall_r;
  assign rec_load_s   = op_br_s & ~stall & ~exc_req & ~mispredict_s;

  // Next fetch PC, highest priority first.
  always_comb begin
    pc_next_s = pc_r + 32'd4;
    if (exc_req) begin
      pc_next_s = EXC_VECTOR;
    end else if (mispredict_s) begin
      pc_next_s = correct_pc_s;
    end else if (stall) begin
      pc_next_s = pc_r;
    end else if (eret_id) begin
      pc_next_s = epc;
    end else if (op_j_s) begin
      pc_next_s = {pc_id[31:28], index_id, 2'b00};
    end else if (op_jr_s) begin
      pc_next_s = gpr_rs_id;
    end else if (op_br_s && pred_s) begin
      pc_next_s = tgt_s;
    end else begin
      pc_next_s = pc_r + 32'd4;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  // ID->EX branch record; anything that is not an issued branch is a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rec_v_r    <= 1'b0;
      rec_bne_r  <= 1'b0;
      rec_pred_r <= 1'b0;
      rec_idx_r  <= {IDX_W{1'b0}};
      rec_tgt_r  <= 32'd0;
      rec_fall_r <= 32'd0;
    end else if (rec_load_s) begin
      rec_v_r    <= 1'b1;
      rec_bne_r  <= op_bne_s;
      rec_pred_r <= pred_s;
      rec_idx_r  <= id_idx_s;
      rec_tgt_r  <= tgt_s;
      rec_fall_r <= fall_s;
    end else begin
      rec_v_r    <= 1'b0;
    end
  end

  // Counter table: train the resolving branch's entry with its real outcome.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_r[i] <= CNT_INIT;
      end
    end else if (resolve_s) begin
      bht_r[rec_idx_r] <= sat_step(bht_r[rec_idx_r], actual_s);
    end
  end

  // Resolution statistics, free-running modulo 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_total_r <= 32'd0;
      br_miss_r  <= 32'd0;
    end else begin
      if (resolve_s) begin
        br_total_r <= br_total_r + 32'd1;
      end
      if (mispredict_s) begin
        br_miss_r <= br_miss_r + 32'd1;
      end
    end
  end

  assign pc_if         = pc_r;
  assign pc_plus4_if   = pc_r + 32'd4;
  assign pc_plus8_if   = pc_r + 32'd8;
  assign pred_taken_id = pred_s;
  assign mispredict    = mispredict_s;
  // Under stall IF/ID holds the delay slot, so only the PC is redirected.
  assign flush_if      = exc_req | (mispredict_s & ~stall) | (eret_id & ~stall);
  assign br_total      = br_total_r;
  assign br_miss       = br_miss_r;

endmodule

// File: tb/tb_npc_bp.sv
// tb_npc_bp -- self-checking bench for npc_bp.
// Directed scenarios follow the block's described use cases; a randomized
// phase compares every cycle against a behavioural model that tracks counters
// as integers and the in-flight branch as a plain record.
module tb_npc_bp;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  jump_op_id;
  logic [31:0] pc_id;
  logic [15:0] offset_id;
  logic [25:0] index_id;
  logic [31:0] gpr_rs_id;
  logic        cmp_eq_ex;
  logic        exc_req;
  logic        eret_id;
  logic [31:0] epc;
  logic [31:0] pc_if;
  logic [31:0] pc_plus4_if;
  logic [31:0] pc_plus8_if;
  logic        pred_taken_id;
  logic        mispredict;
  logic        flush_if;
  logic [31:0] br_total;
  logic [31:0] br_miss;

  npc_bp dut (
    .clk(clk), .reset(reset), .stall(stall), .jump_op_id(jump_op_id),
    .pc_id(pc_id), .offset_id(offset_id), .index_id(index_id),
    .gpr_rs_id(gpr_rs_id), .cmp_eq_ex(cmp_eq_ex), .exc_req(exc_req),
    .eret_id(eret_id), .epc(epc), .pc_if(pc_if), .pc_plus4_if(pc_plus4_if),
    .pc_plus8_if(pc_plus8_if), .pred_taken_id(pred_taken_id),
    .mispredict(mispredict), .flush_if(flush_if), .br_total(br_total),
    .br_miss(br_miss)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int          m_cnt [DEPTH];
  logic [31:0] m_pc;
  logic [31:0] m_total;
  logic [31:0] m_miss;
  bit          p_valid;
  bit          p_bne;
  bit          p_pred;
  logic [31:0] p_pc;
  logic [31:0] p_tgt;
  logic [31:0] p_fall;
  // Model expectations for the current cycle
  bit          e_pred;
  bit          e_resolve;
  bit          e_actual;
  bit          e_mis;
  bit          e_flush;
  logic [31:0] e_next;

  function automatic int slot(input logic [31:0] pc);
    return int'(pc >> 2) % DEPTH;
  endfunction

  function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [15:0] off);
    int woff;
    woff = int'($signed(off));
    return pc + 32'd4 + 32'(woff * 4);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_cnt[i] = 1;
    m_pc = 32'h0000_3000;
    m_total = 32'd0;
    m_miss = 32'd0;
    p_valid = 1'b0;
  endtask

  // Expected combinational outputs and next PC for the present inputs.
  task automatic model_eval();
    bit is_br;
    is_br = (jump_op_id == 3'd1) || (jump_op_id == 3'd2);
    e_pred = (m_cnt[slot(pc_id)] >= 2);
    e_resolve = p_valid && !exc_req;
    e_actual = p_bne ? !cmp_eq_ex : cmp_eq_ex;
    e_mis = e_resolve && (e_actual != p_pred);
    e_flush = exc_req || (e_mis && !stall) || (eret_id && !stall);
    if (exc_req) e_next = 32'h0000_4180;
    else if (e_mis) e_next = e_actual ? p_tgt : p_fall;
    else if (stall) e_next = m_pc;
    else if (eret_id) e_next = epc;
    else if (jump_op_id == 3'd3) e_next = {pc_id[31:28], index_id, 2'b00};
    else if (jump_op_id == 3'd4) e_next = gpr_rs_id;
    else if (is_br && e_pred) e_next = br_target(pc_id, offset_id);
    else e_next = m_pc + 32'd4;
  endtask

  // Clock-edge effects in the model.
  task automatic model_commit();
    int s;
    if (e_resolve) begin
      s = slot(p_pc);
      if (e_actual) begin
        if (m_cnt[s] < 3) m_cnt[s] = m_cnt[s] + 1;
      end else begin
        if (m_cnt[s] > 0) m_cnt[s] = m_cnt[s] - 1;
      end
      m_total = m_total + 32'd1;
      if (e_mis) m_miss = m_miss + 32'd1;
    end
    if ((jump_op_id == 3'd1 || jump_op_id == 3'd2) && !stall && !exc_req && !e_mis) begin
      p_valid = 1'b1;
      p_bne   = (jump_op_id == 3'd2);
      p_pred  = e_pred;
      p_pc    = pc_id;
      p_tgt   = br_target(pc_id, offset_id);
      p_fall  = pc_id + 32'd8;
    end else begin
      p_valid = 1'b0;
    end
    m_pc = e_next;
  endtask

  task automatic to_neg();
    @(negedge clk);
    model_eval();
  endtask

  task automatic to_pos();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set_idle();
    stall = 1'b0; jump_op_id = 3'd0; pc_id = 32'h0000_3000; offset_id = 16'd0;
    index_id = 26'd0; gpr_rs_id = 32'd0; cmp_eq_ex = 1'b0; exc_req = 1'b0;
    eret_id = 1'b0; epc = 32'd0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total++; if (pc_if !== 32'h0000_3000) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc_if, 32'h0000_3000); end
    total++; if (br_total !== 32'd0) begin bad++; $display("FAIL reset_total got=%0d want=0", br_total); end
    total++; if (br_miss !== 32'd0) begin bad++; $display("FAIL reset_miss got=%0d want=0", br_miss); end
    total++; if (mispredict !== 1'b0 || flush_if !== 1'b0) begin bad++; $display("FAIL reset_misflush got=%b%b want=00", mispredict, flush_if); end
    pc_id = 32'h0000_3000 + ($urandom_range(0, 255) << 2); #1;
    total++; if (pred_taken_id !== 1'b0) begin bad++; $display("FAIL reset_pred got=%b want=0", pred_taken_id); end
    model_reset();
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      to_neg(); to_pos();
      total++; if (pc_if !== 32'h0000_3000 + 32'(4 * i)) begin bad++; $display("FAIL seq_pc%0d got=%h want=%h", i, pc_if, 32'h0000_3000 + 32'(4 * i)); end
    end
    total++; if (pc_plus4_if !== 32'h0000_3010 || pc_plus8_if !== 32'h0000_3014) begin bad++; $display("FAIL link got=%h/%h want=00003010/00003014", pc_plus4_if, pc_plus8_if); end
  endtask

  task automatic test_branch_predict();
    jump_op_id = 3'd1; pc_id = 32'h0000_3010; offset_id = 16'd4; cmp_eq_ex = 1'b0;
    to_neg();
    total++; if (pred_taken_id !== 1'b0) begin bad++; $display("FAIL bp_pred1 got=%b want=0", pred_taken_id); end
    to_pos();
    jump_op_id = 3'd0; cmp_eq_ex = 1'b1;
    to_neg();
    total++; if (mispredict !== 1'b1 || flush_if !== 1'b1) begin bad++; $display("FAIL bp_mis got=%b%b want=11", mispredict, flush_if); end
    to_pos();
    total++; if (pc_if !== 32'h0000_3024) begin bad++; $display("FAIL bp_redirect got=%h want=00003024", pc_if); end
    total++; if (br_total !== 32'd1 || br_miss !== 32'd1) begin bad++; $display("FAIL bp_stats got=%0d/%0d want=1/1", br_total, br_miss); end
    jump_op_id = 3'd1; pc_id = 32'h0000_3010; cmp_eq_ex = 1'b0;
    to_neg();
    total++; if (pred_taken_id !== 1'b1) begin bad++; $display("FAIL bp_pred2 got=%b want=1", pred_taken_id); end
    to_pos();
    total++; if (pc_if !== 32'h0000_3024) begin bad++; $display("FAIL bp_predtgt got=%h want=00003024", pc_if); end
    jump_op_id = 3'd0; cmp_eq_ex = 1'b1;
    to_neg();
    total++; if (mispredict !== 1'b0 || flush_if !== 1'b0) begin bad++; $display("FAIL bp_hit got=%b%b want=00", mispredict, flush_if); end
    to_pos();
    total++; if (br_total !== 32'd2 || br_miss !== 32'd1) begin bad++; $display("FAIL bp_stats2 got=%0d/%0d want=2/1", br_total, br_miss); end
  endtask

  task automatic test_bne_saturate();
    bit taken [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      jump_op_id = 3'd2; pc_id = 32'h0000_3080; offset_id = 16'hFFF0; cmp_eq_ex = 1'b0;
      to_neg();
      total++; if (pred_taken_id !== e_pred) begin bad++; $display("FAIL bne_pred%0d got=%b want=%b", k, pred_taken_id, e_pred); end
      to_pos();
      jump_op_id = 3'd0; cmp_eq_ex = !taken[k];
      to_neg();
      total++; if (mispredict !== e_mis) begin bad++; $display("FAIL bne_mis%0d got=%b want=%b", k, mispredict, e_mis); end
      to_pos();
      total++; if (pc_if !== m_pc) begin bad++; $display("FAIL bne_pc%0d got=%h want=%h", k, pc_if, m_pc); end
    end
    total++; if (pc_if !== 32'h0000_3088) begin bad++; $display("FAIL bne_fall got=%h want=00003088", pc_if); end
    total++; if (br_total !== 32'd6 || br_miss !== 32'd3) begin bad++; $display("FAIL bne_stats got=%0d/%0d want=6/3", br_total, br_miss); end
    pc_id = 32'h0000_3080; #1;
    total++; if (pred_taken_id !== 1'b1) begin bad++; $display("FAIL bne_cnt10 got=%b want=1", pred_taken_id); end
  endtask

  task automatic test_mispredict_stall();
    jump_op_id = 3'd1; pc_id = 32'h0000_3200; offset_id = 16'd8; cmp_eq_ex = 1'b0;
    to_neg(); to_pos();
    jump_op_id = 3'd0; stall = 1'b1; cmp_eq_ex = 1'b1;
    to_neg();
    total++; if (mispredict !== 1'b1 || flush_if !== 1'b0) begin bad++; $display("FAIL stall_mis got=%b%b want=10", mispredict, flush_if); end
    to_pos();
    total++; if (pc_if !== 32'h0000_3224) begin bad++; $display("FAIL stall_redirect got=%h want=00003224", pc_if); end
    stall = 1'b0;
  endtask

  task automatic test_exc_eret();
    logic [31:0] tot0;
    jump_op_id = 3'd1; pc_id = 32'h0000_3308; offset_id = 16'd2; cmp_eq_ex = 1'b0;
    to_neg(); to_pos();
    tot0 = m_total;
    jump_op_id = 3'd0; exc_req = 1'b1; cmp_eq_ex = 1'b1;
    to_neg();
    total++; if (mispredict !== 1'b0 || flush_if !== 1'b1) begin bad++; $display("FAIL exc_mis got=%b%b want=01", mispredict, flush_if); end
    to_pos();
    total++; if (pc_if !== 32'h0000_4180) begin bad++; $display("FAIL exc_vec got=%h want=00004180", pc_if); end
    total++; if (br_total !== tot0) begin bad++; $display("FAIL exc_total got=%0d want=%0d", br_total, tot0); end
    exc_req = 1'b0; eret_id = 1'b1; epc = 32'h0000_3040; pc_id = 32'h0000_3308;
    to_neg();
    total++; if (pred_taken_id !== 1'b0) begin bad++; $display("FAIL exc_notrain got=%b want=0", pred_taken_id); end
    total++; if (flush_if !== 1'b1) begin bad++; $display("FAIL eret_flush got=%b want=1", flush_if); end
    to_pos();
    total++; if (pc_if !== 32'h0000_3040) begin bad++; $display("FAIL eret_pc got=%h want=00003040", pc_if); end
    eret_id = 1'b0;
  endtask

  task automatic test_jumps();
    jump_op_id = 3'd4; gpr_rs_id = 32'h0000_3100;
    to_neg();
    total++; if (flush_if !== 1'b0) begin bad++; $display("FAIL jr_flush got=%b want=0", flush_if); end
    to_pos();
    total++; if (pc_if !== 32'h0000_3100) begin bad++; $display("FAIL jr_pc got=%h want=00003100", pc_if); end
    jump_op_id = 3'd3; pc_id = 32'h0000_3020; index_id = 26'h0000C50;
    to_neg(); to_pos();
    total++; if (pc_if !== 32'h0000_3140) begin bad++; $display("FAIL jal_pc got=%h want=00003140", pc_if); end
    stall = 1'b1; index_id = 26'h0000111;
    for (int i = 0; i < 2; i++) begin
      to_neg(); to_pos();
      total++; if (pc_if !== 32'h0000_3140) begin bad++; $display("FAIL stall_hold%0d got=%h want=00003140", i, pc_if); end
    end
    set_idle();
  endtask

  task automatic test_reset_mid_branch();
    jump_op_id = 3'd1; pc_id = 32'h0000_3010; offset_id = 16'd4; cmp_eq_ex = 1'b0;
    to_neg(); to_pos();
    jump_op_id = 3'd0; cmp_eq_ex = 1'b0;
    #1 reset = 1'b0; #1;
    total++; if (pc_if !== 32'h0000_3000 || br_total !== 32'd0) begin bad++; $display("FAIL rst_mid got=%h/%0d want=00003000/0", pc_if, br_total); end
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL rst_mid_mis got=%b want=0", mispredict); end
    pc_id = 32'h0000_3010; #1;
    total++; if (pred_taken_id !== 1'b0) begin bad++; $display("FAIL rst_mid_cnt got=%b want=0", pred_taken_id); end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1; cmp_eq_ex = 1'b0;
    to_neg();
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL rst_lost got=%b want=0", mispredict); end
    to_pos();
    total++; if (pc_if !== 32'h0000_3004 || br_total !== 32'd0) begin bad++; $display("FAIL rst_restart got=%h/%0d want=00003004/0", pc_if, br_total); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      jump_op_id = 3'($urandom_range(0, 7));
      pc_id      = 32'h0000_3000 + 32'($urandom_range(0, 31) * 4);
      offset_id  = 16'($urandom);
      index_id   = 26'($urandom);
      gpr_rs_id  = $urandom;
      cmp_eq_ex  = 1'($urandom_range(0, 1));
      stall      = ($urandom_range(0, 5) == 0);
      exc_req    = ($urandom_range(0, 19) == 0);
      eret_id    = ($urandom_range(0, 9) == 0);
      epc        = $urandom;
      to_neg();
      total++; if (pred_taken_id !== e_pred) begin bad++; $display("FAIL rnd_pred n=%0d got=%b want=%b", n, pred_taken_id, e_pred); end
      total++; if (mispredict !== e_mis) begin bad++; $display("FAIL rnd_mis n=%0d got=%b want=%b", n, mispredict, e_mis); end
      total++; if (flush_if !== e_flush) begin bad++; $display("FAIL rnd_flush n=%0d got=%b want=%b", n, flush_if, e_flush); end
      to_pos();
      total++; if (pc_if !== m_pc) begin bad++; $display("FAIL rnd_pc n=%0d got=%h want=%h", n, pc_if, m_pc); end
      total++; if (br_total !== m_total || br_miss !== m_miss) begin bad++; $display("FAIL rnd_stats n=%0d got=%0d/%0d want=%0d/%0d", n, br_total, br_miss, m_total, m_miss); end
    end
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_branch_predict();
    test_bne_saturate();
    test_mispredict_stall();
    test_exc_eret();
    test_jumps();
    test_reset_mid_branch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/npc_bp.md
# npc_bp

Next-PC generator with PC register and 2-bit branch direction predictor, for the 5-stage MIPS pipeline with branch compare moved to EX. Jumps (j/jal/jr/jalr) resolve in ID. Conditional branches (beq/bne) are predicted in ID from a per-PC bimodal table and verified in EX; a mispredict redirects IF and squashes one wrong-path fetch. The block also owns exception entry, eret return and hazard stalls.

## Interface
- BHT_DEPTH, 64, predictor entries; power of two, 4..1024
- RESET_PC, 32'h0000_3000, PC after reset
- EXC_VECTOR, 32'h0000_4180, exception entry address
- CNT_INIT, 2'b01, counter value after reset (weakly not-taken)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; all state to reset values while low
- stall  in  1  hazard-unit stall; hold PC, ID instruction not issued to EX
- jump_op_id  in  3  ID op: 0 none, 1 beq, 2 bne, 3 j/jal, 4 jr/jalr, 5–7 treated as none
- pc_id  in  32  PC of instruction in ID
- offset_id  in  16  branch immediate
- index_id  in  26  jump index
- gpr_rs_id  in  32  forwarded rs value (jr target)
- cmp_eq_ex  in  1  EX compare result rs==rt for the branch in EX
- exc_req  in  1  take exception this cycle
- eret_id  in  1  eret in ID
- epc  in  32  restart address; used unmodified (no +4)
- pc_if  out  32  fetch PC, registered
- pc_plus4_if, pc_plus8_if  out  32  pc_if+4, pc_if+8 (link values)
- pred_taken_id  out  1  prediction for the ID branch
- mispredict  out  1  EX branch disagrees with its prediction
- flush_if  out  1  clear IF/ID register at next edge
- br_total, br_miss  out  32  resolved-branch / mispredict counts, wrap mod 2^32

## Operation
- Index: idx = pc[log2(BHT_DEPTH)+1:2]. Counter 0–3; predict taken iff bit 1.
- Branch target: tgt = pc_id + 4 + sext(offset_id)<<2. Fall-through: pc_id + 8 (after delay slot).
- EX record {v, pc, pred, tgt, fall}: loaded when jump_op_id∈{1,2} and !stall and !exc_req and !mispredict; else v←0 (bubble).
- Actual taken = v & (beq ? cmp_eq_ex : !cmp_eq_ex). mispredict = v & (actual != pred). Correct PC = actual ? tgt : fall.
- Next pc_if, priority high→low:
  1. exc_req → EXC_VECTOR
  2. mispredict → correct PC
  3. stall → hold
  4. eret_id → epc
  5. op 3 → {pc_id[31:28], index_id, 2'b00}
  6. op 4 → gpr_rs_id
  7. op 1/2 and pred_taken_id → tgt
  8. else pc_if+4
- flush_if = exc_req | (mispredict & !stall) | (eret_id & !stall). With stall, IF/ID holds the delay slot and must not be cleared; redirect still happens.
- On each resolution (v=1): counter[idx(rec.pc)] ±1 saturating at 0/3; br_total+1; br_miss+1 if mispredict.
- exc_req clears the EX record; the EX branch is not counted or trained, and mispredict is forced 0 that cycle.
- A branch in a delay slot is illegal; behaviour is unspecified.

## Timing
- Reset (reset=0): pc_if=RESET_PC, all counters=CNT_INIT, record v=0, br_total=br_miss=0. mispredict=flush_if=0, pred_taken_id=CNT_INIT[1] for any pc_id.
- pc_if, record, counters, statistics update on the rising edge. All other outputs are combinational from current state and inputs.
- Predict→resolve: 1 cycle (ID→EX). Mispredict penalty: exactly one squashed fetch.
- Same-cycle update and lookup of the same index: lookup sees the pre-update value (no bypass).
- Reset deasserted mid-branch: the record is lost, no training, and fetch restarts at RESET_PC.

## Test plan
- Reset release: pc_if=0x3000, advancing +4 per cycle; br_total=0.
- beq at 0x3010 with offset 4, rs==rt, counter 01: prediction not-taken. Next cycle mispredict=1, flush_if=1, next pc_if=0x3024. Counter→10, br_miss=1. Same branch repeated: pred_taken_id=1, pc_if=0x3024, no flush.
- bne taken 3×, then not-taken: counter saturates at 11. Final resolution mispredicts to pc+8, counter→10.
- mispredict with stall=1: pc_if redirected, flush_if=0, IF/ID delay slot retained.
- exc_req together with mispredict: pc_if=0x4180, mispredict=0, counters and br_total unchanged. eret_id with epc=0x3040: pc_if=0x3040, flush_if=1.
- jr with gpr_rs_id=0x3100 and jal index 0x0000C50: pc_if=0x3100 and 0x3140 respectively. Stall holds pc_if.
